// File: rtl/ascon_ctrl_fsm.sv
// Control FSM for ASCON-AEAD128 encryption: one permutation round per clock,
// sequencing initialisation, AD absorption, PT encryption and finalisation.
module ascon_ctrl_fsm #(
    parameter int BLK_W = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [BLK_W-1:0] ad_blocks_i,
    input  logic [BLK_W-1:0] pt_blocks_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic [3:0]       round_o,
    output logic             enable_o,
    output logic             sel_mux_o,
    output logic             ena_xor_up_o,
    output logic             ena_xor_down_o,
    output logic [1:0]       sel_xor_down_o,
    output logic             cipher_valid_o,
    output logic             tag_valid_o,
    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_AD_WAIT = 3'd2,
        S_AD_PERM = 3'd3,
        S_PT_WAIT = 3'd4,
        S_PT_PERM = 3'd5,
        S_FINAL   = 3'd6,
        S_DONE    = 3'd7
    } state_e;

    localparam logic [3:0]       LAST_ROUND = 4'd11;
    localparam logic [BLK_W-1:0] CNT_ZERO   = BLK_W'(0);
    localparam logic [BLK_W-1:0] CNT_ONE    = BLK_W'(1);
    localparam logic [BLK_W-1:0] CNT_TWO    = BLK_W'(2);

    state_e           state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic [BLK_W-1:0] ad_cnt_q, ad_cnt_d;
    logic [BLK_W-1:0] pt_cnt_q, pt_cnt_d;
    logic             start_ok_s;

    assign start_ok_s = (ad_blocks_i != CNT_ZERO) && (pt_blocks_i >= CNT_TWO);

    // State and counter registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            round_q  <= 4'd0;
            ad_cnt_q <= CNT_ZERO;
            pt_cnt_q <= CNT_ZERO;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            ad_cnt_q <= ad_cnt_d;
            pt_cnt_q <= pt_cnt_d;
        end
    end

    // Next-state, round and block-counter logic
    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        ad_cnt_d = ad_cnt_q;
        pt_cnt_d = pt_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && start_ok_s) begin
                    state_d  = S_INIT;
                    round_d  = 4'd0;
                    ad_cnt_d = ad_blocks_i;
                    pt_cnt_d = pt_blocks_i;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                if (round_q == LAST_ROUND) begin
                    state_d = S_AD_WAIT;
                    round_d = 4'd0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_AD_WAIT: begin
                if (data_valid_i) begin
                    state_d  = S_AD_PERM;
                    round_d  = 4'd5;
                    ad_cnt_d = (ad_cnt_q != CNT_ZERO) ? ad_cnt_q - CNT_ONE : CNT_ZERO;
                end else begin
                    state_d = S_AD_WAIT;
                end
            end
            S_AD_PERM: begin
                // Counter already decremented: zero means the last AD block just went in
                if (round_q == LAST_ROUND) begin
                    round_d = 4'd0;
                    state_d = (ad_cnt_q == CNT_ZERO) ? S_PT_WAIT : S_AD_WAIT;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_PT_WAIT: begin
                if (data_valid_i) begin
                    pt_cnt_d = (pt_cnt_q != CNT_ZERO) ? pt_cnt_q - CNT_ONE : CNT_ZERO;
                    if (pt_cnt_q == CNT_ONE) begin
                        state_d = S_FINAL;
                        round_d = 4'd1;
                    end else begin
                        state_d = S_PT_PERM;
                        round_d = 4'd5;
                    end
                end else begin
                    state_d = S_PT_WAIT;
                end
            end
            S_PT_PERM: begin
                if (round_q == LAST_ROUND) begin
                    state_d = S_PT_WAIT;
                    round_d = 4'd0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_FINAL: begin
                if (round_q == LAST_ROUND) begin
                    state_d = S_DONE;
                    round_d = 4'd0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                round_d = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                round_d = 4'd0;
            end
        endcase
    end

    // Datapath control and handshake outputs
    always_comb begin
        data_ready_o   = 1'b0;
        round_o        = 4'd0;
        enable_o       = 1'b0;
        sel_mux_o      = 1'b1;
        ena_xor_up_o   = 1'b0;
        ena_xor_down_o = 1'b0;
        sel_xor_down_o = 2'b00;
        cipher_valid_o = 1'b0;
        tag_valid_o    = 1'b0;
        busy_o         = 1'b0;
        err_o          = 1'b0;
        case (state_q)
            S_IDLE: begin
                err_o = start_i && !start_ok_s && !reset_i;
            end
            S_INIT: begin
                busy_o    = 1'b1;
                enable_o  = 1'b1;
                round_o   = round_q;
                sel_mux_o = (round_q != 4'd0);
                if (round_q == LAST_ROUND) begin
                    ena_xor_down_o = 1'b1;
                    sel_xor_down_o = 2'b00;
                end else begin
                    ena_xor_down_o = 1'b0;
                end
            end
            S_AD_WAIT: begin
                busy_o       = 1'b1;
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    enable_o     = 1'b1;
                    ena_xor_up_o = 1'b1;
                    round_o      = 4'd4;
                end else begin
                    enable_o = 1'b0;
                end
            end
            S_AD_PERM: begin
                busy_o   = 1'b1;
                enable_o = 1'b1;
                round_o  = round_q;
                if ((round_q == LAST_ROUND) && (ad_cnt_q == CNT_ZERO)) begin
                    ena_xor_down_o = 1'b1;
                    sel_xor_down_o = 2'b01;
                end else begin
                    ena_xor_down_o = 1'b0;
                end
            end
            S_PT_WAIT: begin
                busy_o       = 1'b1;
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    enable_o       = 1'b1;
                    ena_xor_up_o   = 1'b1;
                    cipher_valid_o = 1'b1;
                    round_o        = (pt_cnt_q == CNT_ONE) ? 4'd0 : 4'd4;
                end else begin
                    enable_o = 1'b0;
                end
            end
            S_PT_PERM: begin
                busy_o   = 1'b1;
                enable_o = 1'b1;
                round_o  = round_q;
                // Finalisation key lands early; it commutes with the last block's xor_up
                if ((round_q == LAST_ROUND) && (pt_cnt_q == CNT_ONE)) begin
                    ena_xor_down_o = 1'b1;
                    sel_xor_down_o = 2'b10;
                end else begin
                    ena_xor_down_o = 1'b0;
                end
            end
            S_FINAL: begin
                busy_o   = 1'b1;
                enable_o = 1'b1;
                round_o  = round_q;
                if (round_q == LAST_ROUND) begin
                    ena_xor_down_o = 1'b1;
                    sel_xor_down_o = 2'b11;
                end else begin
                    ena_xor_down_o = 1'b0;
                end
            end
            S_DONE: begin
                tag_valid_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Self-checking bench for ascon_ctrl_fsm: a per-cycle expected trace is built from
// the operation's block counts and stall pattern, then replayed against the DUT.
module tb_ascon_ctrl_fsm;
    localparam int BLK_W = 8;

    logic             clk = 1'b0;
    logic             reset_i, start_i, data_valid_i;
    logic [BLK_W-1:0] ad_blocks_i, pt_blocks_i;
    logic             data_ready_o, enable_o, sel_mux_o, ena_xor_up_o, ena_xor_down_o;
    logic             cipher_valid_o, tag_valid_o, busy_o, err_o;
    logic [3:0]       round_o;
    logic [1:0]       sel_xor_down_o;
    logic [13:0]      dut_vec;

    always #5 clk = ~clk;

    ascon_ctrl_fsm #(.BLK_W(BLK_W)) dut (
        .clock_i(clk), .reset_i(reset_i), .start_i(start_i),
        .ad_blocks_i(ad_blocks_i), .pt_blocks_i(pt_blocks_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
        .round_o(round_o), .enable_o(enable_o), .sel_mux_o(sel_mux_o),
        .ena_xor_up_o(ena_xor_up_o), .ena_xor_down_o(ena_xor_down_o),
        .sel_xor_down_o(sel_xor_down_o), .cipher_valid_o(cipher_valid_o),
        .tag_valid_o(tag_valid_o), .busy_o(busy_o), .err_o(err_o)
    );

    assign dut_vec = {data_ready_o, round_o, enable_o, sel_mux_o, ena_xor_up_o,
                      ena_xor_down_o, sel_xor_down_o, cipher_valid_o, tag_valid_o,
                      busy_o, err_o};

    typedef struct packed {
        logic        s;
        logic        v;
        logic [13:0] o;
    } step_t;

    step_t tr[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    int    cur_a, cur_p;
    int    first_rdy, mux0_cnt;
    int    obs_cip[$];
    int    obs_tag[$];
    int    xd_cnt[4];

    function automatic logic [13:0] pk(input logic rdy, input int rnd, input logic en,
                                       input logic mux, input logic xu, input logic xd,
                                       input logic [1:0] sxd, input logic cv,
                                       input logic tg, input logic bz, input logic er);
        logic [3:0] r4;
        r4 = rnd[3:0];
        return {rdy, r4, en, mux, xu, xd, sxd, cv, tg, bz, er};
    endfunction

    localparam logic [13:0] IDLE_V = {1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00,
                                      1'b0, 1'b0, 1'b0, 1'b0};

    function automatic step_t mk(input logic s, input logic v, input logic [13:0] o);
        step_t t;
        t.s = s;
        t.v = v;
        t.o = o;
        return t;
    endfunction

    function automatic logic rv();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected cycle-by-cycle behaviour of one encryption, from the state-sequence rules
    task automatic build(input int a, input int p, input int stall, input bit hold);
        int  st;
        bit  lst;
        tr.delete();
        cur_a = a;
        cur_p = p;
        tr.push_back(mk(1'b1, rv(), IDLE_V));
        for (int r = 0; r < 12; r++)
            tr.push_back(mk(hold, rv(), pk(1'b0, r, 1'b1, r != 0, 1'b0, r == 11, 2'b00,
                                            1'b0, 1'b0, 1'b1, 1'b0)));
        for (int b = 0; b < a; b++) begin
            st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int k = 0; k < st; k++)
                tr.push_back(mk(hold, 1'b0, pk(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00,
                                                1'b0, 1'b0, 1'b1, 1'b0)));
            tr.push_back(mk(hold, 1'b1, pk(1'b1, 4, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00,
                                            1'b0, 1'b0, 1'b1, 1'b0)));
            for (int r = 5; r < 12; r++) begin
                lst = (r == 11) && (b == a - 1);
                tr.push_back(mk(hold, rv(), pk(1'b0, r, 1'b1, 1'b1, 1'b0, lst,
                                                lst ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b1, 1'b0)));
            end
        end
        for (int b = 0; b < p; b++) begin
            st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int k = 0; k < st; k++)
                tr.push_back(mk(hold, 1'b0, pk(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00,
                                                1'b0, 1'b0, 1'b1, 1'b0)));
            if (b < p - 1) begin
                tr.push_back(mk(hold, 1'b1, pk(1'b1, 4, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00,
                                                1'b1, 1'b0, 1'b1, 1'b0)));
                for (int r = 5; r < 12; r++) begin
                    lst = (r == 11) && (b == p - 2);
                    tr.push_back(mk(hold, rv(), pk(1'b0, r, 1'b1, 1'b1, 1'b0, lst,
                                                    lst ? 2'b10 : 2'b00, 1'b0, 1'b0, 1'b1, 1'b0)));
                end
            end else begin
                tr.push_back(mk(hold, 1'b1, pk(1'b1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00,
                                                1'b1, 1'b0, 1'b1, 1'b0)));
                for (int r = 1; r < 12; r++)
                    tr.push_back(mk(hold, rv(), pk(1'b0, r, 1'b1, 1'b1, 1'b0, r == 11,
                                                    (r == 11) ? 2'b11 : 2'b00, 1'b0, 1'b0, 1'b1, 1'b0)));
            end
        end
        tr.push_back(mk(hold, rv(), pk(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00,
                                        1'b0, 1'b1, 1'b0, 1'b0)));
    endtask

    task automatic run(input int abort_at);
        first_rdy = -1;
        mux0_cnt  = 0;
        obs_cip.delete();
        obs_tag.delete();
        for (int k = 0; k < 4; k++) xd_cnt[k] = 0;
        for (int i = 0; i < tr.size(); i++) begin
            @(negedge clk);
            start_i      = tr[i].s;
            data_valid_i = tr[i].v;
            if (i == 0) begin
                ad_blocks_i = cur_a[BLK_W-1:0];
                pt_blocks_i = cur_p[BLK_W-1:0];
            end else begin
                ad_blocks_i = BLK_W'($urandom);
                pt_blocks_i = BLK_W'($urandom);
            end
            if (i == abort_at) reset_i = 1'b1;
            #1;
            chk($sformatf("trace[%0d]", i), {18'd0, dut_vec}, {18'd0, tr[i].o});
            if (data_ready_o && first_rdy < 0) first_rdy = i - 1;
            if (cipher_valid_o) obs_cip.push_back(i - 1);
            if (tag_valid_o) obs_tag.push_back(i - 1);
            if (ena_xor_down_o) xd_cnt[sel_xor_down_o]++;
            if (!sel_mux_o) mux0_cnt++;
            if (i == abort_at) break;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start_i      = 1'b0;
            data_valid_i = rv();
            #1;
            chk("idle", {18'd0, dut_vec}, {18'd0, IDLE_V});
        end
    endtask

    task automatic err_try(input int a, input int p);
        @(negedge clk);
        start_i     = 1'b1;
        ad_blocks_i = a[BLK_W-1:0];
        pt_blocks_i = p[BLK_W-1:0];
        #1;
        chk("err_pulse", {31'd0, err_o}, 32'd1);
        chk("err_busy", {31'd0, busy_o}, 32'd0);
        idle_cycles(4);
    endtask

    initial begin
        reset_i      = 1'b1;
        start_i      = 1'b0;
        data_valid_i = 1'b0;
        ad_blocks_i  = '0;
        pt_blocks_i  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_vec", {18'd0, dut_vec}, {18'd0, IDLE_V});
        reset_i = 1'b0;

        // Minimal run: latency and pulse positions
        build(1, 2, 0, 1'b0);
        run(-1);
        chk("first_ready", first_rdy, 12);
        chk("cipher_n", obs_cip.size(), 2);
        chk("cipher0", (obs_cip.size() > 0) ? obs_cip[0] : -1, 20);
        chk("cipher1", (obs_cip.size() > 1) ? obs_cip[1] : -1, 28);
        chk("tag_n", obs_tag.size(), 1);
        chk("tag_cyc", (obs_tag.size() > 0) ? obs_tag[0] : -1, 40);
        for (int k = 0; k < 4; k++) chk($sformatf("xd_sel%0d", k), xd_cnt[k], 1);
        chk("mux0", mux0_cnt, 1);

        // Stalls of 5 cycles before every block
        build(2, 3, 5, 1'b0);
        run(-1);
        chk("stall_cipher_n", obs_cip.size(), 3);
        chk("stall_tag_n", obs_tag.size(), 1);

        // Rejected starts
        err_try(0, 3);
        err_try(1, 1);
        err_try(0, 0);

        // Reset during the third AD_PERM cycle
        build(2, 2, 0, 1'b0);
        run(16);
        @(negedge clk);
        reset_i = 1'b0;
        start_i = 1'b0;
        #1;
        chk("after_reset", {18'd0, dut_vec}, {18'd0, IDLE_V});
        idle_cycles(3);
        build(1, 3, -1, 1'b0);
        run(-1);
        chk("post_reset_tag_n", obs_tag.size(), 1);
        chk("post_reset_cipher_n", obs_cip.size(), 3);

        // start_i held high across a whole run, then a second run back to back
        build(1, 2, 0, 1'b1);
        run(-1);
        chk("hold_mux0", mux0_cnt, 1);
        chk("hold_tag_n", obs_tag.size(), 1);
        build(2, 2, -1, 1'b0);
        run(-1);
        chk("hold2_mux0", mux0_cnt, 1);
        chk("hold2_tag_n", obs_tag.size(), 1);

        // Randomized operations
        for (int n = 0; n < 8; n++) begin
            build(int'($urandom_range(1, 3)), int'($urandom_range(2, 4)), -1, 1'b0);
            run(-1);
            chk($sformatf("rnd%0d_tag_n", n), obs_tag.size(), 1);
            chk($sformatf("rnd%0d_cipher_n", n), obs_cip.size(), cur_p);
        end
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
